fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch (IF) stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It holds the PC, issues one request per instruction to a variable-latency instruction memory, and presents `{pc, inst}` on `IF_ID_bus` with `IF_over` once the word returns. It selects the next PC from three sources: the WB-stage exception/ERET redirect, the decode-stage jump/branch bus, and sequential PC+4. Branch-delay-slot semantics are preserved.

## Interface
- `RESET_PC`, default 32'h0000_0034: PC fetched first after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `IF_valid`  in  1  pipeline control permits IF to issue fetches.
- `next_fetch`  in  1  ID accepts the held instruction this cycle; advance PC.
- `jbr_bus`  in  33  `{jbr_taken, jbr_target[31:0]}` from decode.
- `exc_bus`  in  33  `{exc_valid, exc_pc[31:0]}` from WB (SYSCALL entry, ERET return).
- `inst_req`  out  1  one-cycle request pulse to instruction memory.
- `inst_addr`  out  32  request address; equals the PC register.
- `inst_rdata`  in  32  returned instruction word.
- `inst_rvalid`  in  1  `inst_rdata` is valid; arrives at least 1 cycle after `inst_req`.
- `IF_over`  out  1  the held instruction is complete and valid.
- `IF_ID_bus`  out  64  `{pc, inst}`, stable while `IF_over` is high.
- `IF_pc`  out  32  PC register, for display.
- `IF_inst`  out  32  held instruction, for display.

## Operation
**State machine:** states REQ, WAIT, DONE, DROP.
- **REQ**
  - If `IF_valid`: assert `inst_req`, go to WAIT.
  - Otherwise stay in REQ with `inst_req` low.
- **WAIT**
  - On `inst_rvalid`: capture `inst_rdata` into the inst register, go to DONE.
- **DONE**
  - `IF_over` = 1 & ~`exc_valid`.
  - On `next_fetch`: PC <= next_pc, go to REQ.
- **DROP**
  - Waits for the response to the fetch cancelled by an exception, then discards it.
  - On `inst_rvalid`: go to REQ. The inst register is not written.

**next_pc priority:**
1. `exc_valid`: next_pc = `exc_pc`.
2. `jbr_taken` this cycle: next_pc = `jbr_target`.
3. `pend_valid`: next_pc = `pend_target`.
4. Otherwise: next_pc = PC+4. Wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0.

**Jump/branch capture:**
- If `jbr_taken` is high and the redirect is not consumed by `next_fetch` in the same cycle: `pend_valid` <= 1, `pend_target` <= `jbr_target`.
- A later `jbr_taken` overwrites a pending target.
- `pend_valid` clears when the redirect is used (`next_fetch` in DONE) or on `exc_valid`.
- The instruction held in DONE when the branch resolves is the delay slot. It is always delivered, never squashed by `jbr_taken`.

**Exception redirect (`exc_valid` = 1):** applies in any state. PC <= `exc_pc`, `pend_valid` <= 0. Next state by current state:
- REQ with `inst_req` asserted this cycle: DROP.
- WAIT with no `inst_rvalid` this cycle: DROP.
- WAIT with `inst_rvalid` this cycle: REQ, response discarded.
- DONE: REQ. The held instruction is withdrawn; `next_fetch` in that cycle is ignored.
- DROP: stays DROP with the updated PC.
- REQ with `inst_req` low: REQ.

**Other rules:**
- `inst_rvalid` outside WAIT/DROP is ignored.
- The PC changes only on `next_fetch` in DONE or on `exc_valid`.

## Timing
- **Reset values:**
  - state = REQ, PC = `RESET_PC`, inst = 0, `pend_valid` = 0, `pend_target` = 0.
  - `inst_req` = 0, `IF_over` = 0, `IF_ID_bus` = {`RESET_PC`, 0}.
  - `inst_addr` = `IF_pc` = `RESET_PC`, `IF_inst` = 0.
  - Reset asserted mid-fetch abandons the fetch immediately. After release, the first `inst_req` occurs in the first cycle with `IF_valid` high.
- **Fetch latency:** memory latency L ≥ 1.
  - `inst_req` in cycle t, `inst_rvalid` in cycle t+L.
  - `IF_over` is high from cycle t+L+1.
  - Minimum of 3 cycles per instruction when `next_fetch` is immediate.
- **`next_fetch` in DONE at cycle n:** `inst_req` at cycle n+1 with `inst_addr` = new PC.
- **Combinational outputs:**
  - `inst_req` = (state == REQ) & `IF_valid`.
  - `inst_addr` = PC.
  - `IF_over` = (state == DONE) & ~`exc_valid`.
- **At most one request outstanding;** no new `inst_req` before the response returns.

## Test plan
- **Sequential fetch:** release reset, `IF_valid` = 1, L = 1, `next_fetch` tied high.
  - `inst_addr` = 0x34, 0x38, 0x3C, with `inst_req` every 3rd cycle.
  - `IF_ID_bus` = {0x34, word0} with `IF_over` high in cycle 3.
- **Variable latency:** L = 4, `next_fetch` delayed 2 cycles after `IF_over`.
  - `IF_over` rises exactly 5 cycles after `inst_req`.
  - `IF_ID_bus` is held constant until `next_fetch`.
  - No `inst_req` while in WAIT or DONE.
- **Branch with delay slot:** at PC 0x40 (delay slot, in DONE), `jbr_bus` = {1, 0x100} together with `next_fetch`.
  - 0x40 is delivered; the next `inst_addr` = 0x100.
  - Repeat with `jbr_taken` arriving 1 cycle before `next_fetch`: the pending target is used, so the next fetch is again 0x100.
- **Exception during WAIT:** L = 3; `exc_bus` = {1, 0x380} one cycle after `inst_req`.
  - The late `inst_rvalid` is dropped and inst is unchanged.
  - The next `inst_req` has `inst_addr` = 0x380.
  - `IF_over` stays low until 0x380's word returns.
- **Exception in DONE with simultaneous `next_fetch` and pending branch:**
  - `IF_over` is low that cycle.
  - PC = 0x380 and `pend_valid` = 0.
  - The next fetch is 0x380, not the branch target or PC+4.
- **Reset and stall corners:**
  - Assert `resetn` low in WAIT: all outputs take reset values immediately.
  - Hold `IF_valid` = 0 for 5 cycles: no `inst_req`.
  - PC 0xFFFF_FFFC followed by `next_fetch`: next `inst_addr` = 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request,
// and next-PC selection between exception, jump/branch and PC+4.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0034
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        IF_valid,
    input  logic        next_fetch,
    input  logic [32:0] jbr_bus,
    input  logic [32:0] exc_bus,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        inst_rvalid,
    output logic        IF_over,
    output logic [63:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_t_q, pend_t_d;

    logic        jbr_taken;
    logic [31:0] jbr_target;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        advance;
    logic [31:0] next_pc;

    assign jbr_taken  = jbr_bus[32];
    assign jbr_target = jbr_bus[31:0];
    assign exc_valid  = exc_bus[32];
    assign exc_pc     = exc_bus[31:0];

    assign advance = (state_q == S_DONE) & next_fetch & ~exc_valid;

    always_comb begin
        next_pc = pc_q + 32'd4;
        if (exc_valid) begin
            next_pc = exc_pc;
        end else if (jbr_taken) begin
            next_pc = jbr_target;
        end else if (pend_v_q) begin
            next_pc = pend_t_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pend_v_d = pend_v_q;
        pend_t_d = pend_t_q;

        unique case (state_q)
            S_REQ: begin
                if (IF_valid) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (inst_rvalid) begin
                    state_d = S_DONE;
                    inst_d  = inst_rdata;
                end
            end
            S_DONE: begin
                if (next_fetch) begin
                    state_d = S_REQ;
                    pc_d    = next_pc;
                end
            end
            S_DROP: begin
                if (inst_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // A redirect not consumed this cycle is held until the next advance.
        if (advance) begin
            pend_v_d = 1'b0;
        end else if (jbr_taken) begin
            pend_v_d = 1'b1;
            pend_t_d = jbr_target;
        end

        // Exceptions override everything; a request still in flight must
        // be drained through DROP so its response is not mistaken for ours.
        if (exc_valid) begin
            pc_d     = exc_pc;
            pend_v_d = 1'b0;
            inst_d   = inst_q;
            unique case (state_q)
                S_REQ:   state_d = IF_valid ? S_DROP : S_REQ;
                S_WAIT:  state_d = inst_rvalid ? S_REQ : S_DROP;
                S_DONE:  state_d = S_REQ;
                S_DROP:  state_d = inst_rvalid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            inst_q   <= 32'd0;
            pend_v_q <= 1'b0;
            pend_t_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pend_v_q <= pend_v_d;
            pend_t_q <= pend_t_d;
        end
    end

    assign inst_req  = (state_q == S_REQ) & IF_valid;
    assign inst_addr = pc_q;
    assign IF_over   = (state_q == S_DONE) & ~exc_valid;
    assign IF_ID_bus = {pc_q, inst_q};
    assign IF_pc     = pc_q;
    assign IF_inst   = inst_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected request addresses and
// delivered {pc, inst} words are queued and checked by a monitor.
module tb_fetch_stage;

    logic        clk;
    logic        resetn;
    logic        IF_valid;
    logic        next_fetch;
    logic [32:0] jbr_bus;
    logic [32:0] exc_bus;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;
    logic        IF_over;
    logic [63:0] IF_ID_bus;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;

    int total = 0;
    int bad   = 0;
    int mem_lat = 1;

    logic [31:0] req_q[$];
    logic [63:0] out_q[$];

    fetch_stage dut (
        .clk        (clk),
        .resetn     (resetn),
        .IF_valid   (IF_valid),
        .next_fetch (next_fetch),
        .jbr_bus    (jbr_bus),
        .exc_bus    (exc_bus),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_rvalid(inst_rvalid),
        .IF_over    (IF_over),
        .IF_ID_bus  (IF_ID_bus),
        .IF_pc      (IF_pc),
        .IF_inst    (IF_inst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_over(input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!IF_over && k < 40);
        check(nm, {63'd0, IF_over}, 64'd1);
    endtask

    task automatic wait_acc(input string nm, input int n);
        int got = 0;
        int k = 0;
        while (got < n && k < 60) begin
            @(negedge clk);
            k++;
            if (IF_over && next_fetch) got++;
        end
        check(nm, 64'(got), 64'(n));
    endtask

    // Instruction memory: word = addr + 0x1000_0000, latency mem_lat.
    initial begin
        inst_rvalid = 1'b0;
        inst_rdata  = 32'd0;
        forever begin
            logic [31:0] a;
            int lat;
            @(negedge clk);
            if (inst_req) begin
                a   = inst_addr;
                lat = mem_lat;
                repeat (lat) @(posedge clk);
                #1;
                inst_rvalid = 1'b1;
                inst_rdata  = a + 32'h1000_0000;
                @(posedge clk);
                #1;
                inst_rvalid = 1'b0;
            end
        end
    end

    // Monitor: every request and every accepted instruction is scored.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && inst_req) begin
                if (req_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_unexpected actual=%h required=none",
                             inst_addr);
                end else begin
                    check("req_addr", {32'd0, inst_addr}, {32'd0, req_q.pop_front()});
                end
            end
            if (resetn && IF_over && next_fetch) begin
                if (out_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected actual=%h required=none",
                             IF_ID_bus);
                end else begin
                    check("if_id_bus", IF_ID_bus, out_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [63:0] held;
        int k;
        resetn     = 1'b0;
        IF_valid   = 1'b0;
        next_fetch = 1'b0;
        jbr_bus    = 33'd0;
        exc_bus    = 33'd0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {63'd0, inst_req}, 64'd0);
        check("rst_over", {63'd0, IF_over}, 64'd0);
        check("rst_bus", IF_ID_bus, {32'h34, 32'h0});
        check("rst_addr", {32'd0, inst_addr}, 64'h34);
        check("rst_inst", {32'd0, IF_inst}, 64'h0);
        tick();
        resetn = 1'b1;
        tick();

        // sequential fetch, L=1, next_fetch tied high
        req_q.push_back(32'h34);
        req_q.push_back(32'h38);
        req_q.push_back(32'h3C);
        out_q.push_back({32'h34, 32'h1000_0034});
        out_q.push_back({32'h38, 32'h1000_0038});
        out_q.push_back({32'h3C, 32'h1000_003C});
        tick();
        mem_lat    = 1;
        IF_valid   = 1'b1;
        next_fetch = 1'b1;
        @(negedge clk);
        check("seq_req0", {63'd0, inst_req}, 64'd1);
        @(negedge clk);
        check("seq_wait", {63'd0, IF_over}, 64'd0);
        @(negedge clk);
        check("seq_over", {63'd0, IF_over}, 64'd1);
        check("seq_bus0", IF_ID_bus, {32'h34, 32'h1000_0034});
        @(negedge clk);
        check("seq_req1", {63'd0, inst_req}, 64'd1);
        wait_acc("seq_acc", 2);
        tick();
        IF_valid   = 1'b0;
        next_fetch = 1'b0;

        // variable latency L=4, next_fetch 2 cycles late
        req_q.push_back(32'h40);
        out_q.push_back({32'h40, 32'h1000_0040});
        tick();
        mem_lat  = 4;
        IF_valid = 1'b1;
        @(negedge clk);
        check("lat_req", {63'd0, inst_req}, 64'd1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!IF_over && k < 20);
        check("lat_cycles", 64'(k), 64'd5);
        held = IF_ID_bus;
        check("lat_bus", held, {32'h40, 32'h1000_0040});
        @(negedge clk);
        check("lat_hold", IF_ID_bus, {32'h40, 32'h1000_0040});
        tick();
        next_fetch = 1'b1;
        @(negedge clk);
        tick();
        next_fetch = 1'b0;
        IF_valid   = 1'b0;

        // redirect PC to 0x40 while idle
        tick();
        exc_bus = {1'b1, 32'h40};
        tick();
        exc_bus = 33'd0;
        @(negedge clk);
        check("idle_redir", {32'd0, IF_pc}, 64'h40);

        // branch resolving together with next_fetch
        req_q.push_back(32'h40);
        req_q.push_back(32'h100);
        req_q.push_back(32'h100);
        out_q.push_back({32'h40, 32'h1000_0040});
        out_q.push_back({32'h100, 32'h1000_0100});
        mem_lat = 1;
        tick();
        IF_valid = 1'b1;
        wait_over("br_over0");
        tick();
        jbr_bus    = {1'b1, 32'h100};
        next_fetch = 1'b1;
        @(negedge clk);
        tick();
        jbr_bus    = 33'd0;
        next_fetch = 1'b0;
        wait_over("br_over1");

        // branch one cycle before next_fetch: pending target used
        tick();
        jbr_bus = {1'b1, 32'h100};
        @(negedge clk);
        check("br_slot_kept", {63'd0, IF_over}, 64'd1);
        tick();
        jbr_bus    = 33'd0;
        next_fetch = 1'b1;
        @(negedge clk);
        tick();
        next_fetch = 1'b0;
        wait_over("br_over2");

        // exception in DONE with next_fetch and a pending branch
        tick();
        jbr_bus = {1'b1, 32'h200};
        req_q.push_back(32'h380);
        tick();
        jbr_bus    = 33'd0;
        exc_bus    = {1'b1, 32'h380};
        next_fetch = 1'b1;
        @(negedge clk);
        check("exd_over", {63'd0, IF_over}, 64'd0);
        tick();
        exc_bus    = 33'd0;
        next_fetch = 1'b0;
        @(negedge clk);
        check("exd_pc", {32'd0, IF_pc}, 64'h380);
        wait_over("exd_over2");
        check("exd_bus", IF_ID_bus, {32'h380, 32'h1000_0380});
        out_q.push_back({32'h380, 32'h1000_0380});
        req_q.push_back(32'h384);
        tick();
        mem_lat    = 3;
        next_fetch = 1'b1;
        @(negedge clk);
        tick();
        next_fetch = 1'b0;
        @(negedge clk);

        // exception one cycle after request, L=3
        tick();
        exc_bus = {1'b1, 32'h380};
        req_q.push_back(32'h380);
        @(negedge clk);
        check("exw_over", {63'd0, IF_over}, 64'd0);
        tick();
        exc_bus = 33'd0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            check("exw_drop_over", {63'd0, IF_over}, 64'd0);
        end while (!inst_req && k < 20);
        check("exw_req_delay", 64'(k), 64'd3);
        check("exw_inst_kept", {32'd0, IF_inst}, 64'h1000_0380);
        wait_over("exw_over2");
        check("exw_bus", IF_ID_bus, {32'h380, 32'h1000_0380});
        out_q.push_back({32'h380, 32'h1000_0380});
        tick();
        next_fetch = 1'b1;
        @(negedge clk);
        tick();
        next_fetch = 1'b0;
        IF_valid   = 1'b0;

        // stall: no requests while IF_valid is low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req", {63'd0, inst_req}, 64'd0);
        end

        // PC wrap-around
        tick();
        exc_bus = {1'b1, 32'hFFFF_FFFC};
        tick();
        exc_bus = 33'd0;
        req_q.push_back(32'hFFFF_FFFC);
        req_q.push_back(32'h0);
        out_q.push_back({32'hFFFF_FFFC, 32'h0FFF_FFFC});
        mem_lat = 1;
        tick();
        IF_valid   = 1'b1;
        next_fetch = 1'b1;
        wait_over("wrap_over");
        tick();
        mem_lat    = 4;
        next_fetch = 1'b0;
        @(negedge clk);
        check("wrap_pc", {32'd0, IF_pc}, 64'h0);

        // reset asserted in WAIT
        tick();
        resetn   = 1'b0;
        IF_valid = 1'b0;
        #1;
        check("mrst_req", {63'd0, inst_req}, 64'd0);
        check("mrst_over", {63'd0, IF_over}, 64'd0);
        check("mrst_bus", IF_ID_bus, {32'h34, 32'h0});
        check("mrst_pc", {32'd0, IF_pc}, 64'h34);
        check("mrst_addr", {32'd0, inst_addr}, 64'h34);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b1;
        mem_lat = 1;
        tick();
        req_q.push_back(32'h34);
        out_q.push_back({32'h34, 32'h1000_0034});
        tick();
        IF_valid   = 1'b1;
        next_fetch = 1'b1;
        @(negedge clk);
        check("post_rst_req", {63'd0, inst_req}, 64'd1);
        wait_over("post_rst_over");
        tick();
        IF_valid   = 1'b0;
        next_fetch = 1'b0;
        repeat (3) @(negedge clk);

        check("req_q_empty", 64'(req_q.size()), 64'd0);
        check("out_q_empty", 64'(out_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
